// File: rtl/tick_monitor.sv
// tick_monitor: measures the interval between tick pulses, flags early/late ticks and latches a fault after repeated misses
module tick_monitor #(
  parameter int NOMINAL_PERIOD = 100_000_000,
  parameter int TOLERANCE = 1000,
  parameter int MISS_LIMIT = 3,
  localparam int PW = $clog2(NOMINAL_PERIOD + TOLERANCE + 2),
  localparam int MW = $clog2(MISS_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pulse_in,
  input  logic          clear_fault,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          early,
  output logic          late,
  output logic [MW-1:0] miss_cnt,
  output logic          fault
);
  typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAULT} state_t;
  localparam logic [PW-1:0] MAXC = PW'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [PW-1:0] MINP = PW'(NOMINAL_PERIOD - TOLERANCE);
  localparam logic [MW-1:0] LIM = MW'(MISS_LIMIT);
  state_t state;
  logic [PW-1:0] cnt, cnt_nx;
  logic [MW-1:0] miss_nx;
  logic timeout, short_iv, bad;
  assign cnt_nx = cnt + PW'(1);
  assign miss_nx = miss_cnt + MW'(1);
  assign timeout = cnt == MAXC;
  assign short_iv = cnt_nx < MINP;
  // a pulse on the timeout cycle is a late tick, not a separate timeout
  assign bad = pulse_in ? (state == TRACK && (short_iv || timeout)) : timeout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      period <= '0;
      period_valid <= 1'b0;
      early <= 1'b0;
      late <= 1'b0;
      miss_cnt <= '0;
      fault <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      early <= 1'b0;
      late <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt <= '0;
        miss_cnt <= '0;
        fault <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SYNC;
            cnt <= '0;
          end
          FAULT: begin
            cnt <= '0;
            if (clear_fault) begin
              state <= SYNC;
              miss_cnt <= '0;
              fault <= 1'b0;
            end
          end
          default: begin
            cnt <= (pulse_in || timeout) ? '0 : cnt_nx;
            if (pulse_in && state == SYNC) state <= TRACK;
            if (pulse_in && state == TRACK) begin
              period <= cnt_nx;
              period_valid <= 1'b1;
              early <= short_iv;
              late <= timeout;
            end else if (!pulse_in && timeout) begin
              late <= 1'b1;
            end
            if (bad) begin
              miss_cnt <= miss_nx;
              if (miss_nx == LIM) begin
                state <= FAULT;
                fault <= 1'b1;
              end
            end else if (pulse_in && state == TRACK) begin
              miss_cnt <= '0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tick_monitor.sv
// tb_tick_monitor: directed and random tick streams checked against a time-stamp based reference model
module tb_tick_monitor;
  localparam int N = 10, T = 2, ML = 3;
  logic clk = 0, rst = 1, en = 0, pulse_in = 0, clear_fault = 0;
  logic [3:0] period;
  logic [1:0] miss_cnt;
  logic period_valid, early, late, fault;
  int checks = 0, passed = 0, cyc = 0, m_ref = 0, m_mode = 0, m_miss = 0;
  logic [3:0] m_period = 0;
  logic m_pv = 0, m_early = 0, m_late = 0;

  tick_monitor #(.NOMINAL_PERIOD(N), .TOLERANCE(T), .MISS_LIMIT(ML)) dut (
    .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in), .clear_fault(clear_fault),
    .period(period), .period_valid(period_valid), .early(early), .late(late),
    .miss_cnt(miss_cnt), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] act();
    return {period, period_valid, early, late, miss_cnt, fault};
  endfunction

  function automatic logic [9:0] expv();
    return {m_period, m_pv, m_early, m_late, 2'(m_miss), m_mode == 3};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_period = 0; m_pv = 0; m_early = 0; m_late = 0; m_miss = 0;
  endtask

  // mode: 0 idle, 1 waiting for first tick, 2 tracking, 3 fault; m_ref = cycle of last real or virtual tick
  task automatic step(input logic e, input logic p, input logic cf);
    int iv;
    logic bad;
    en = e; pulse_in = p; clear_fault = cf;
    @(posedge clk);
    cyc++;
    iv = cyc - m_ref;
    bad = 0; m_pv = 0; m_early = 0; m_late = 0;
    if (!e) begin
      m_mode = 0; m_miss = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_ref = cyc;
    end else if (m_mode == 3) begin
      if (cf) begin m_mode = 1; m_miss = 0; m_ref = cyc; end
    end else if (p) begin
      if (m_mode == 2) begin
        m_period = 4'(iv); m_pv = 1;
        m_early = iv < N - T; m_late = iv > N + T;
        bad = m_early | m_late;
        if (!bad) m_miss = 0;
      end
      m_mode = 2; m_ref = cyc;
    end else if (iv == N + T + 1) begin
      m_late = 1; bad = 1; m_ref = cyc;
    end
    if (bad) begin
      m_miss++;
      if (m_miss >= ML) m_mode = 3;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act() !== 10'b0) $display("FAIL reset got=%b exp=%b", act(), 10'b0); else passed++;
    rst = 0;
    model_reset();
  endtask

  task automatic test_steady();
    int ivs[4] = '{3, 10, 10, 10};
    step(1, 0, 0);
    checks++;
    if (act() !== expv()) $display("FAIL steady_enable got=%b exp=%b", act(), expv()); else passed++;
    for (int i = 0; i < 4; i++) begin
      for (int k = 1; k <= ivs[i]; k++) begin
        step(1, k == ivs[i], 0);
        checks++;
        if (act() !== expv()) $display("FAIL steady_model cyc=%0d got=%b exp=%b", cyc, act(), expv()); else passed++;
      end
      checks++;
      if (i == 0) begin
        if (period_valid !== 1'b0) $display("FAIL steady_first got pv=%b exp pv=0", period_valid); else passed++;
      end else if ({period, period_valid, early, late, miss_cnt} !== {4'd10, 1'b1, 1'b0, 1'b0, 2'd0})
        $display("FAIL steady_tick got=%b exp=%b", {period, period_valid, early, late, miss_cnt}, {4'd10, 5'b10000});
      else passed++;
    end
  endtask

  task automatic test_early();
    int ivs[3] = '{10, 7, 10};
    logic [8:0] want[3] = '{{4'd10, 5'b10000}, {4'd7, 5'b11001}, {4'd10, 5'b10000}};
    for (int i = 0; i < 3; i++) begin
      for (int k = 1; k <= ivs[i]; k++) begin
        step(1, k == ivs[i], 0);
        checks++;
        if (act() !== expv()) $display("FAIL early_model cyc=%0d got=%b exp=%b", cyc, act(), expv()); else passed++;
      end
      checks++;
      if ({period, period_valid, early, late, miss_cnt} !== want[i])
        $display("FAIL early_tick%0d got=%b exp=%b", i, {period, period_valid, early, late, miss_cnt}, want[i]);
      else passed++;
    end
  endtask

  task automatic test_boundary();
    int ivs[3] = '{8, 12, 13};
    logic [8:0] want[3] = '{{4'd8, 5'b10000}, {4'd12, 5'b10000}, {4'd13, 5'b10101}};
    for (int i = 0; i < 3; i++) begin
      for (int k = 1; k <= ivs[i]; k++) begin
        step(1, k == ivs[i], 0);
        checks++;
        if (act() !== expv()) $display("FAIL bound_model cyc=%0d got=%b exp=%b", cyc, act(), expv()); else passed++;
      end
      checks++;
      if ({period, period_valid, early, late, miss_cnt} !== want[i])
        $display("FAIL bound_tick%0d got=%b exp=%b", i, {period, period_valid, early, late, miss_cnt}, want[i]);
      else passed++;
    end
    step(1, 0, 0);
    checks++;
    if ({period_valid, early, late} !== 3'b000) $display("FAIL bound_no_timeout got=%b exp=000", {period_valid, early, late}); else passed++;
    for (int k = 1; k <= 9; k++) begin
      step(1, k == 9, 0);
      checks++;
      if (act() !== expv()) $display("FAIL bound_resync cyc=%0d got=%b exp=%b", cyc, act(), expv()); else passed++;
    end
  endtask

  task automatic test_loss();
    int ivs[2] = '{10, 10};
    for (int k = 1; k <= 39; k++) begin
      step(1, 0, 0);
      checks++;
      if (act() !== expv()) $display("FAIL loss_model cyc=%0d got=%b exp=%b", cyc, act(), expv()); else passed++;
      if (k % 13 == 0) begin
        checks++;
        if ({late, miss_cnt, fault} !== {1'b1, 2'(k / 13), k == 39})
          $display("FAIL loss_timeout k=%0d got=%b exp=%b", k, {late, miss_cnt, fault}, {1'b1, 2'(k / 13), k == 39});
        else passed++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      step(1, k[0], 0);
      checks++;
      if ({period_valid, early, late, fault} !== 4'b0001) $display("FAIL fault_ignore got=%b exp=0001", {period_valid, early, late, fault}); else passed++;
    end
    step(1, 1, 1);
    checks++;
    if ({period_valid, miss_cnt, fault} !== 4'b0) $display("FAIL fault_clear got=%b exp=0000", {period_valid, miss_cnt, fault}); else passed++;
    for (int i = 0; i < 2; i++) begin
      for (int k = 1; k <= ivs[i]; k++) begin
        step(1, k == ivs[i], 0);
        checks++;
        if (act() !== expv()) $display("FAIL resync_model cyc=%0d got=%b exp=%b", cyc, act(), expv()); else passed++;
      end
      checks++;
      if ({period_valid, period} !== (i == 0 ? {1'b0, period} : {1'b1, 4'd10}))
        $display("FAIL resync_tick%0d got pv=%b period=%0d", i, period_valid, period);
      else passed++;
    end
  endtask

  task automatic test_disable();
    for (int k = 1; k <= 39; k++) begin
      step(1, 0, 0);
      checks++;
      if (act() !== expv()) $display("FAIL dis_model cyc=%0d got=%b exp=%b", cyc, act(), expv()); else passed++;
    end
    step(0, 1, 1);
    checks++;
    if ({miss_cnt, fault} !== 3'b000) $display("FAIL dis_fault got=%b exp=000", {miss_cnt, fault}); else passed++;
    for (int k = 0; k < 6; k++) begin
      step(0, k[0], 0);
      checks++;
      if (act() !== expv() || {period_valid, early, late} !== 3'b0)
        $display("FAIL dis_ignore got=%b exp=%b", act(), expv());
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    int ivs[2] = '{5, 10};
    step(1, 0, 0);
    for (int i = 0; i < 2; i++)
      for (int k = 1; k <= ivs[i]; k++) begin
        step(1, k == ivs[i], 0);
        checks++;
        if (act() !== expv()) $display("FAIL ares_model cyc=%0d got=%b exp=%b", cyc, act(), expv()); else passed++;
      end
    checks++;
    if (period_valid !== 1'b1) $display("FAIL ares_pre got pv=%b exp pv=1", period_valid); else passed++;
    step(1, 0, 0);
    #2 rst = 1;
    #1;
    checks++;
    if (act() !== 10'b0) $display("FAIL ares_now got=%b exp=%b", act(), 10'b0); else passed++;
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int iv = $urandom_range(1, 15);
      for (int k = 1; k <= iv; k++) begin
        step($urandom_range(0, 39) != 0, k == iv, m_mode == 3 && $urandom_range(0, 3) == 0);
        checks++;
        if (act() !== expv()) $display("FAIL random cyc=%0d got=%b exp=%b", cyc, act(), expv()); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_early();
    test_boundary();
    test_loss();
    test_disable();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
